// File: rtl/pe_mac.sv
// -----------------------------------------------------------------------------
// pe_mac: single signed multiply-accumulate processing element.
//
// Each enabled cycle one signed feature is multiplied by one signed weight.
// The full-precision product is added into a registered accumulator, and that
// accumulator drives the output directly. A dual-lane PE is built from two
// instances. The two lanes share pe_row_weight, pe_row_vld and pe_array_vld.
// Each lane has its own pe_row_input, pe_col_vld and pe_row_output.
//
// Ports:
//   clk           in   1             clock, rising edge
//   rstn          in   1             asynchronous active-low reset
//   clr_i         in   1             synchronous accumulator clear (beats enable)
//   pe_row_input  in   FEATURE_WD    signed feature operand
//   pe_row_weight in   WEIGHT_WD     signed weight operand
//   pe_row_output out  PE_OUTPUT_WD  signed accumulator value, registered
//   pe_col_vld    in   1             column valid
//   pe_row_vld    in   1             row valid
//   pe_array_vld  in   1             array-level valid
//
// Valid semantics: there is no ready/back-pressure. A MAC is consumed on a
// rising edge when all three valids are high and clr_i is low. If any valid
// is low, the operands are ignored and the accumulator holds its value.
//
// PE_OUTPUT_WD must be at least FEATURE_WD+WEIGHT_WD. Sums beyond the
// accumulator range wrap modulo 2^PE_OUTPUT_WD. There is no saturation.
// -----------------------------------------------------------------------------
module pe_mac #(
  parameter int FEATURE_WD   = 8,
  parameter int WEIGHT_WD    = 8,
  parameter int PE_OUTPUT_WD = 18
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr_i,
  input  logic [FEATURE_WD-1:0]   pe_row_input,
  input  logic [WEIGHT_WD-1:0]    pe_row_weight,
  output logic [PE_OUTPUT_WD-1:0] pe_row_output,
  input  logic                    pe_col_vld,
  input  logic                    pe_row_vld,
  input  logic                    pe_array_vld
);

  localparam int PROD_WD = FEATURE_WD + WEIGHT_WD;

  logic                           en;
  logic signed [PROD_WD-1:0]      prod;
  logic signed [PE_OUTPUT_WD-1:0] prod_ext;
  logic        [PE_OUTPUT_WD-1:0] acc;

  assign en = pe_col_vld & pe_row_vld & pe_array_vld;

  // Both operands are signed and the result is PROD_WD bits wide, so the
  // product is exact. This includes the most-negative * most-negative case.
  assign prod = $signed(pe_row_input) * $signed(pe_row_weight);

  // A size cast of a signed value sign-extends it. This is also valid when
  // PE_OUTPUT_WD == PROD_WD, where a zero-width replication would be illegal.
  assign prod_ext = PE_OUTPUT_WD'(prod);

  // Clear has priority over enable. If both are high in the same cycle, no
  // product is added and the result is zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
    end else if (clr_i) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

  assign pe_row_output = acc;

endmodule

// File: tb/tb_pe_mac.sv
// -----------------------------------------------------------------------------
// tb_pe_mac: self-checking bench for pe_mac.
//
// The reference model keeps the running value as a plain modular sum. Each
// driven cycle adds f*w, or clears the value to zero, and then keeps only the
// low PE_OUTPUT_WD bits. The expected output for every driven cycle goes into
// exp_q. A compare process checks one queued value just after each rising
// edge. Hand-computed literal expectations from the directed scenarios pin the
// model itself.
// -----------------------------------------------------------------------------
module tb_pe_mac;

  localparam int FW = 8;
  localparam int WW = 8;
  localparam int PW = 18;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          rstn;
  logic          clr_i;
  logic [FW-1:0] pe_row_input;
  logic [WW-1:0] pe_row_weight;
  logic [PW-1:0] pe_row_output;
  logic          pe_col_vld;
  logic          pe_row_vld;
  logic          pe_array_vld;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pe_mac #(
    .FEATURE_WD  (FW),
    .WEIGHT_WD   (WW),
    .PE_OUTPUT_WD(PW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .clr_i        (clr_i),
    .pe_row_input (pe_row_input),
    .pe_row_weight(pe_row_weight),
    .pe_row_output(pe_row_output),
    .pe_col_vld   (pe_col_vld),
    .pe_row_vld   (pe_row_vld),
    .pe_array_vld (pe_array_vld)
  );

  // ---------------- scoreboard ----------------
  int            checks = 0;
  int            errors = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] model_acc;

  function automatic int to_int(input logic [PW-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic check(input string name, input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)",
               name, to_int(act), act, to_int(exp), exp);
    end
  endtask

  task automatic check_lit(input string name, input int exp);
    check(name, pe_row_output, PW'(exp));
  endtask

  // Checks the DUT against the model on every rising edge that was driven
  // while reset was released.
  always @(posedge clk) begin
    #1;
    if (rstn && exp_q.size() > 0) begin
      logic [PW-1:0] e;
      e = exp_q.pop_front();
      check("model", pe_row_output, e);
    end
  end

  // ---------------- driver ----------------
  // Drives one cycle of inputs, updates the model, queues the expected output
  // for the coming edge, and then returns at the following falling edge.
  task automatic mac_cycle(input logic clr, input int f, input int w,
                           input logic col, input logic row, input logic arr);
    clr_i         = clr;
    pe_row_input  = FW'(f);
    pe_row_weight = WW'(w);
    pe_col_vld    = col;
    pe_row_vld    = row;
    pe_array_vld  = arr;
    if (clr)
      model_acc = '0;
    else if (col && row && arr)
      model_acc = model_acc + PW'(f * w);
    exp_q.push_back(model_acc);
    @(negedge clk);
  endtask

  task automatic mac(input int f, input int w);
    mac_cycle(1'b0, f, w, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic idle();
    mac_cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear();
    mac_cycle(1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn          = 1'b0;
    clr_i         = 1'b0;
    pe_row_input  = '0;
    pe_row_weight = '0;
    pe_col_vld    = 1'b0;
    pe_row_vld    = 1'b0;
    pe_array_vld  = 1'b0;
    model_acc     = '0;

    // Reset and hold.
    @(negedge clk);
    @(negedge clk);
    check_lit("reset_value", 0);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) idle();
    check_lit("hold_after_reset", 0);

    // Basic accumulate.
    mac(3, 4);      check_lit("basic_12", 12);
    mac(-5, 7);     check_lit("basic_m23", -23);
    mac(127, -128); check_lit("basic_m16279", -16279);

    // Enable gating: each enable term dropped in turn.
    clear();
    mac(10, 10);                            check_lit("gate_setup_100", 100);
    mac_cycle(1'b0, 10, 10, 1'b0, 1'b1, 1'b1); check_lit("gate_col", 100);
    mac_cycle(1'b0, 10, 10, 1'b1, 1'b0, 1'b1); check_lit("gate_row", 100);
    mac_cycle(1'b0, 10, 10, 1'b1, 1'b1, 1'b0); check_lit("gate_array", 100);
    mac(10, 10);                            check_lit("gate_all_200", 200);

    // Clear priority over enable.
    clear();
    mac(25, 20);                               check_lit("clr_setup_500", 500);
    mac_cycle(1'b1, 2, 2, 1'b1, 1'b1, 1'b1);   check_lit("clr_with_en", 0);
    mac(2, 2);                                 check_lit("clr_then_4", 4);

    // Extreme products and wrap-around.
    clear();
    for (int i = 0; i < 7; i++) mac(-128, -128);
    check_lit("extreme_114688", 114688);
    mac(-128, -128);
    check_lit("wrap_m131072", -131072);
    clear();
    mac(-128, 127);
    check_lit("extreme_m16256", -16256);

    // Asynchronous reset between edges.
    clear();
    mac(25, 40);
    check_lit("async_setup_1000", 1000);
    pe_col_vld   = 1'b0;
    pe_row_vld   = 1'b0;
    pe_array_vld = 1'b0;
    #2 rstn = 1'b0;
    #1 check_lit("async_reset_now", 0);
    model_acc = '0;
    #1 rstn = 1'b1;
    exp_q.push_back(model_acc);
    @(negedge clk);
    check_lit("async_hold_0", 0);
    mac(1, 1);
    check_lit("async_resume_1", 1);

    // Let the compare process drain the queue.
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_mac.md
Name: pe_mac

Overview:
- Single signed multiply-accumulate processing element for the PE array.
- Each enabled cycle: one signed feature times one signed weight, added into a registered accumulator.
- The accumulator drives the output directly.
- Two instances, sharing weight, row-valid and array-valid, form a dual-lane PE.
  - Each lane has its own feature slice, column-valid and output slice.

Parameters:
- FEATURE_WD, 8: width of the signed two's-complement feature input.
- WEIGHT_WD, 8: width of the signed two's-complement weight input.
- PE_OUTPUT_WD, 18: width of the signed accumulator and output. Must be ≥ FEATURE_WD+WEIGHT_WD.

Ports:
- clk, input, 1: clock, rising edge.
- rstn, input, 1: asynchronous active-low reset.
- clr_i, input, 1: synchronous accumulator clear.
- pe_row_input, input, FEATURE_WD: signed feature operand.
- pe_row_weight, input, WEIGHT_WD: signed weight operand.
- pe_row_output, output, PE_OUTPUT_WD: signed accumulator value, registered.
- pe_col_vld, input, 1: column valid.
- pe_row_vld, input, 1: row valid.
- pe_array_vld, input, 1: array-level valid.

Behaviour:
- Reset: reset rstn, asynchronous, active-low; clock clk. While rstn=0 the accumulator is 0, so pe_row_output=0.
- Enable: en = pe_col_vld & pe_row_vld & pe_array_vld.
- Product:
  - prod = signed(pe_row_input) * signed(pe_row_weight), full precision, FEATURE_WD+WEIGHT_WD bits (16 with defaults).
  - prod is sign-extended to PE_OUTPUT_WD before the add.
- Register update at each rising clk, in priority order:
  1. rstn=0 (async): acc <= 0.
  2. clr_i=1: acc <= 0, regardless of en. No product is added that cycle.
  3. en=1: acc <= acc + prod.
  4. Otherwise: acc holds.
- Output: pe_row_output = acc. Purely registered, with no combinational path from inputs to output.
- Latency: a product sampled at edge N is visible in pe_row_output after edge N.
  - Back-to-back enables accumulate every cycle, so throughput is 1 MAC/cycle.
- Overflow: two's-complement modulo 2^PE_OUTPUT_WD wrap-around. No saturation and no overflow flag.
- Operand extremes: -128*-128 = 16384 must be exact. The product range is [-16256, 16384].
- Any enable term low gates the update. Operands are don't-care when en=0.
- clr_i and en high together: the result is 0, not prod.
- Reset asserted mid-accumulation clears immediately, without waiting for clk. Accumulation resumes from 0 after release.
- X-free: every state bit is reset.

Test Plan:
- Reset and hold:
  - Assert rstn=0 -> output 0.
  - Release rstn with en=0 for 5 cycles -> output stays 0.
- Basic accumulate:
  - Drive en=1 with (3,4), then (-5,7), then (127,-128) on consecutive cycles.
  - Required outputs after each edge: 12, then -23, then -16279.
- Enable gating:
  - Set acc=100. Drive operands (10,10) with each of pe_col_vld, pe_row_vld, pe_array_vld dropped in turn -> output stays 100.
  - Then all three enables high for 1 cycle -> 200.
- Clear priority:
  - Set acc=500. Drive clr_i=1 with en=1 and operands (2,2) -> output 0.
  - Next cycle drive clr_i=0, en=1, operands (2,2) -> 4.
- Extreme products and wrap:
  - From 0, accumulate (-128,-128) 7 times -> 114688.
  - 114688 exceeds the 18-bit maximum of 131071? No: it is 114688 < 131071, so continue. An 8th accumulation (total 131072) wraps -> output -131072.
  - Check (-128,127) from 0 -> -16256.
- Async reset mid-run:
  - Accumulate to 1000, then pulse rstn low between clock edges -> output becomes 0 before the next edge.
  - After release, accumulate (1,1) -> 1.
